// File: rtl/segre_pkg.sv
// Shared types and sizes for the segre core memory path.
package segre_pkg;

    localparam int ADDR_SIZE       = 32;
    localparam int WORD_SIZE       = 32;
    localparam int SB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        ST_WAIT,
        FENCE_DONE
    } sb_arb_state_e;

endpackage

// File: rtl/segre_sb_drain_arbiter.sv
// Arbitrates the single data-cache port between load misses and store-buffer
// drains, with a drain-all fence and a starvation guard for pending stores.
module segre_sb_drain_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE    = segre_pkg::ADDR_SIZE,
    parameter int WORD_SIZE    = segre_pkg::WORD_SIZE,
    parameter int STARVE_LIMIT = segre_pkg::SB_STARVE_LIMIT
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ld_req_i,
    input  logic [ADDR_SIZE-1:0] ld_addr_i,
    input  memop_data_type_e     ld_memop_i,
    output logic                 ld_done_o,
    output logic [WORD_SIZE-1:0] ld_data_o,
    input  logic                 sb_valid_i,
    input  logic                 sb_full_i,
    input  logic [ADDR_SIZE-1:0] sb_addr_i,
    input  logic [WORD_SIZE-1:0] sb_data_i,
    input  memop_data_type_e     sb_memop_i,
    output logic                 sb_pop_o,
    input  logic                 fence_i,
    output logic                 fence_done_o,
    output logic                 stall_o,
    output logic                 cache_req_o,
    output logic                 cache_we_o,
    output logic [ADDR_SIZE-1:0] cache_addr_o,
    output logic [WORD_SIZE-1:0] cache_data_o,
    output memop_data_type_e     cache_memop_o,
    input  logic                 cache_ready_i,
    input  logic                 cache_rsp_i,
    input  logic [WORD_SIZE-1:0] cache_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    sb_arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;
    memop_data_type_e       memop_q, memop_d;
    logic                   we_q, we_d;
    logic                   cache_req_q, cache_req_d;
    logic                   ld_done_q, ld_done_d;
    logic [WORD_SIZE-1:0]   ld_data_q, ld_data_d;
    logic                   sb_pop_q, sb_pop_d;
    logic                   fence_done_q, fence_done_d;
    logic                   grant_ld;
    logic                   grant_st;
    logic                   no_grant;

    // The done/pop cycle still shows the just-served request (ld_req_i held
    // until done, stale sb tail until the pop edge), so it never grants.
    assign no_grant = ld_done_q | sb_pop_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        memop_d      = memop_q;
        we_d         = we_q;
        ld_data_d    = ld_data_q;
        ld_done_d    = 1'b0;
        sb_pop_d     = 1'b0;
        fence_done_d = 1'b0;
        grant_ld     = 1'b0;
        grant_st     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!no_grant) begin
                    if (fence_i && sb_valid_i) begin
                        grant_st = 1'b1;
                    end else if (fence_i) begin
                        state_d      = FENCE_DONE;
                        fence_done_d = 1'b1;
                    end else if (sb_full_i && sb_valid_i) begin
                        grant_st = 1'b1;
                    end else if (sb_valid_i && (cnt_q == LIMIT_C)) begin
                        grant_st = 1'b1;
                    end else if (ld_req_i) begin
                        grant_ld = 1'b1;
                    end else if (sb_valid_i) begin
                        grant_st = 1'b1;
                    end
                end
            end
            LD_REQ: begin
                if (cache_ready_i) state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (cache_rsp_i) begin
                    state_d   = IDLE;
                    ld_done_d = 1'b1;
                    ld_data_d = cache_rdata_i;
                end
            end
            ST_REQ: begin
                if (cache_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cache_rsp_i) begin
                    state_d  = IDLE;
                    sb_pop_d = 1'b1;
                end
            end
            FENCE_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_st) begin
            state_d = ST_REQ;
            we_d    = 1'b1;
            addr_d  = sb_addr_i;
            data_d  = sb_data_i;
            memop_d = sb_memop_i;
            cnt_d   = '0;
        end

        if (grant_ld) begin
            state_d = LD_REQ;
            we_d    = 1'b0;
            addr_d  = ld_addr_i;
            memop_d = ld_memop_i;
            if (sb_valid_i && (cnt_q != LIMIT_C)) cnt_d = cnt_q + 1'b1;
        end

        cache_req_d = (state_d == LD_REQ) || (state_d == ST_REQ);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            memop_q      <= BYTE;
            we_q         <= 1'b0;
            cache_req_q  <= 1'b0;
            ld_done_q    <= 1'b0;
            ld_data_q    <= '0;
            sb_pop_q     <= 1'b0;
            fence_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            memop_q      <= memop_d;
            we_q         <= we_d;
            cache_req_q  <= cache_req_d;
            ld_done_q    <= ld_done_d;
            ld_data_q    <= ld_data_d;
            sb_pop_q     <= sb_pop_d;
            fence_done_q <= fence_done_d;
        end
    end

    assign cache_req_o   = cache_req_q;
    assign cache_we_o    = we_q;
    assign cache_addr_o  = addr_q;
    assign cache_data_o  = data_q;
    assign cache_memop_o = memop_q;
    assign ld_done_o     = ld_done_q;
    assign ld_data_o     = ld_data_q;
    assign sb_pop_o      = sb_pop_q;
    assign fence_done_o  = fence_done_q;

    assign stall_o = (ld_req_i & ~ld_done_q) | (fence_i & ~fence_done_q) | sb_full_i;

endmodule

// File: tb/tb_segre_sb_drain_arbiter.sv
// Directed bench for segre_sb_drain_arbiter: loads, drains, starvation, fence, reset.
module tb_segre_sb_drain_arbiter;
  import segre_pkg::*;

  logic             clk_i = 1'b0;
  logic             rsn_i;
  logic             ld_req_i;
  logic [31:0]      ld_addr_i;
  memop_data_type_e ld_memop_i;
  logic             ld_done_o;
  logic [31:0]      ld_data_o;
  logic             sb_valid_i;
  logic             sb_full_i;
  logic [31:0]      sb_addr_i;
  logic [31:0]      sb_data_i;
  memop_data_type_e sb_memop_i;
  logic             sb_pop_o;
  logic             fence_i;
  logic             fence_done_o;
  logic             stall_o;
  logic             cache_req_o;
  logic             cache_we_o;
  logic [31:0]      cache_addr_o;
  logic [31:0]      cache_data_o;
  memop_data_type_e cache_memop_o;
  logic             cache_ready_i;
  logic             cache_rsp_i;
  logic [31:0]      cache_rdata_i;

  int n_total = 0;
  int n_pass  = 0;

  segre_sb_drain_arbiter dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .ld_req_i      (ld_req_i),
    .ld_addr_i     (ld_addr_i),
    .ld_memop_i    (ld_memop_i),
    .ld_done_o     (ld_done_o),
    .ld_data_o     (ld_data_o),
    .sb_valid_i    (sb_valid_i),
    .sb_full_i     (sb_full_i),
    .sb_addr_i     (sb_addr_i),
    .sb_data_i     (sb_data_i),
    .sb_memop_i    (sb_memop_i),
    .sb_pop_o      (sb_pop_o),
    .fence_i       (fence_i),
    .fence_done_o  (fence_done_o),
    .stall_o       (stall_o),
    .cache_req_o   (cache_req_o),
    .cache_we_o    (cache_we_o),
    .cache_addr_o  (cache_addr_o),
    .cache_data_o  (cache_data_o),
    .cache_memop_o (cache_memop_o),
    .cache_ready_i (cache_ready_i),
    .cache_rsp_i   (cache_rsp_i),
    .cache_rdata_i (cache_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic        acc;
  int          ngr;
  logic [9:0]  order;
  logic        g_we   [3];
  logic [31:0] g_addr [3];
  int          g_cyc  [3];
  int          fdone_cnt;
  int          fdone_cyc;
  int          pop_cnt;
  logic        pending_pop;
  logic        drop_fence;
  logic        ld_seen;

  initial begin
    rsn_i         = 1'b0;
    ld_req_i      = 1'b0;
    ld_addr_i     = '0;
    ld_memop_i    = WORD;
    sb_valid_i    = 1'b0;
    sb_full_i     = 1'b0;
    sb_addr_i     = '0;
    sb_data_i     = '0;
    sb_memop_i    = WORD;
    fence_i       = 1'b0;
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b0;
    cache_rdata_i = '0;

    // reset state
    #12;
    chk("rst_req", cache_req_o, 1'b0);
    chk("rst_done", ld_done_o, 1'b0);
    chk("rst_pop", sb_pop_o, 1'b0);
    chk("rst_fdone", fence_done_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    nxt();
    rsn_i = 1'b1;

    // load with ready on 2nd REQ cycle, rsp 3 cycles after acceptance
    ld_req_i   = 1'b1;
    ld_addr_i  = 32'h40;
    ld_memop_i = WORD;
    @(negedge clk_i);
    chk("ld_idle_req", cache_req_o, 1'b0);
    chk("ld_stall0", stall_o, 1'b1);
    nxt();
    @(negedge clk_i);
    chk("ld_req1", cache_req_o, 1'b1);
    chk("ld_we", cache_we_o, 1'b0);
    chk("ld_addr", cache_addr_o, 32'h40);
    nxt();
    cache_ready_i = 1'b1;
    @(negedge clk_i);
    chk("ld_req2", cache_req_o, 1'b1);
    nxt();
    cache_ready_i = 1'b0;
    @(negedge clk_i);
    chk("ld_req_drop", cache_req_o, 1'b0);
    chk("ld_wait_stall", stall_o, 1'b1);
    nxt();
    @(negedge clk_i);
    chk("ld_no_done", ld_done_o, 1'b0);
    nxt();
    cache_rsp_i   = 1'b1;
    cache_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("ld_no_done2", ld_done_o, 1'b0);
    nxt();
    cache_rsp_i = 1'b0;
    @(negedge clk_i);
    chk("ld_done", ld_done_o, 1'b1);
    chk("ld_data", ld_data_o, 32'hDEADBEEF);
    chk("ld_stall_done", stall_o, 1'b0);
    nxt();
    ld_req_i = 1'b0;
    @(negedge clk_i);
    chk("ld_done_once", ld_done_o, 1'b0);
    chk("ld_no_regrant", cache_req_o, 1'b0);
    nxt();

    // drain held through 3 not-ready cycles
    sb_valid_i = 1'b1;
    sb_addr_i  = 32'h100;
    sb_data_i  = 32'hA5A5A5A5;
    sb_memop_i = WORD;
    nxt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("st_req", cache_req_o, 1'b1);
      chk("st_we", cache_we_o, 1'b1);
      chk("st_addr", cache_addr_o, 32'h100);
      chk("st_data", cache_data_o, 32'hA5A5A5A5);
      chk("st_memop", cache_memop_o, WORD);
      nxt();
    end
    cache_ready_i = 1'b1;
    nxt();
    cache_ready_i = 1'b0;
    @(negedge clk_i);
    chk("st_req_drop", cache_req_o, 1'b0);
    chk("st_no_pop", sb_pop_o, 1'b0);
    nxt();
    cache_rsp_i = 1'b1;
    nxt();
    cache_rsp_i = 1'b0;
    @(negedge clk_i);
    chk("st_pop", sb_pop_o, 1'b1);
    nxt();
    sb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("st_pop_once", sb_pop_o, 1'b0);
    chk("st_no_regrant", cache_req_o, 1'b0);
    nxt();

    // starvation guard: continuous loads and a pending drain
    ld_req_i   = 1'b1;
    ld_addr_i  = 32'h80;
    sb_valid_i = 1'b1;
    sb_addr_i  = 32'h200;
    acc        = 1'b0;
    ngr        = 0;
    order      = '0;
    for (int c = 0; c < 100 && ngr < 10; c++) begin
      cache_ready_i = 1'b1;
      cache_rsp_i   = acc;
      @(negedge clk_i);
      if (cache_req_o) begin
        order[ngr] = cache_we_o;
        ngr++;
      end
      acc = cache_req_o & cache_ready_i;
      nxt();
    end
    ld_req_i   = 1'b0;
    sb_valid_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cache_rsp_i = acc;
      @(negedge clk_i);
      acc = cache_req_o & cache_ready_i;
      nxt();
    end
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b0;
    chk("starve_ngr", ngr, 10);
    chk("starve_order", order, 10'b10000_10000);

    // sb_full overrides a pending load
    sb_full_i  = 1'b1;
    sb_valid_i = 1'b1;
    sb_addr_i  = 32'h204;
    sb_data_i  = 32'h11223344;
    ld_req_i   = 1'b1;
    ld_addr_i  = 32'h84;
    @(negedge clk_i);
    chk("full_stall0", stall_o, 1'b1);
    nxt();
    cache_ready_i = 1'b1;
    @(negedge clk_i);
    chk("full_req", cache_req_o, 1'b1);
    chk("full_we", cache_we_o, 1'b1);
    chk("full_stall1", stall_o, 1'b1);
    nxt();
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b1;
    @(negedge clk_i);
    chk("full_stall2", stall_o, 1'b1);
    nxt();
    cache_rsp_i = 1'b0;
    @(negedge clk_i);
    chk("full_pop", sb_pop_o, 1'b1);
    chk("full_stall3", stall_o, 1'b1);
    nxt();
    sb_full_i  = 1'b0;
    sb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("full_gap", cache_req_o, 1'b0);
    chk("full_stall4", stall_o, 1'b1);
    nxt();
    cache_ready_i = 1'b1;
    @(negedge clk_i);
    chk("full_ld_req", cache_req_o, 1'b1);
    chk("full_ld_we", cache_we_o, 1'b0);
    chk("full_ld_addr", cache_addr_o, 32'h84);
    nxt();
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b1;
    cache_rdata_i = 32'h000055AA;
    nxt();
    cache_rsp_i = 1'b0;
    @(negedge clk_i);
    chk("full_ld_done", ld_done_o, 1'b1);
    chk("full_ld_data", ld_data_o, 32'h000055AA);
    nxt();
    ld_req_i = 1'b0;

    // fence with two entries and a pending load
    fence_i     = 1'b1;
    sb_valid_i  = 1'b1;
    sb_addr_i   = 32'h300;
    sb_data_i   = 32'hCAFE0001;
    ld_req_i    = 1'b1;
    ld_addr_i   = 32'hC0;
    ld_memop_i  = HALF;
    acc         = 1'b0;
    ngr         = 0;
    fdone_cnt   = 0;
    fdone_cyc   = 0;
    pop_cnt     = 0;
    pending_pop = 1'b0;
    drop_fence  = 1'b0;
    ld_seen     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g_we[i]   = 1'bx;
      g_addr[i] = 'x;
      g_cyc[i]  = -1;
    end
    for (int c = 0; c < 40 && !ld_seen; c++) begin
      cache_ready_i = 1'b1;
      cache_rsp_i   = acc;
      cache_rdata_i = 32'h0BADF00D;
      if (pending_pop) begin
        pop_cnt++;
        if (pop_cnt == 1) begin
          sb_addr_i = 32'h304;
          sb_data_i = 32'hCAFE0002;
        end else begin
          sb_valid_i = 1'b0;
        end
        pending_pop = 1'b0;
      end
      if (drop_fence) fence_i = 1'b0;
      @(negedge clk_i);
      if (c == 0) chk("fence_stall", stall_o, 1'b1);
      if (cache_req_o && ngr < 3) begin
        g_we[ngr]   = cache_we_o;
        g_addr[ngr] = cache_addr_o;
        g_cyc[ngr]  = c;
        ngr++;
      end
      if (fence_done_o) begin
        fdone_cnt++;
        fdone_cyc  = c;
        drop_fence = 1'b1;
      end
      if (sb_pop_o) pending_pop = 1'b1;
      if (ld_done_o) ld_seen = 1'b1;
      acc = cache_req_o & cache_ready_i;
      nxt();
    end
    ld_req_i      = 1'b0;
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b0;
    chk("fence_ngr", ngr, 3);
    chk("fence_g0_we", g_we[0], 1'b1);
    chk("fence_g0_addr", g_addr[0], 32'h300);
    chk("fence_g1_we", g_we[1], 1'b1);
    chk("fence_g1_addr", g_addr[1], 32'h304);
    chk("fence_g2_we", g_we[2], 1'b0);
    chk("fence_g2_addr", g_addr[2], 32'hC0);
    chk("fence_done_cnt", fdone_cnt, 1);
    chk("fence_before_ld", (g_cyc[2] > fdone_cyc), 1'b1);
    chk("fence_ld_done", ld_seen, 1'b1);

    // asynchronous reset in ST_WAIT
    sb_valid_i = 1'b1;
    sb_addr_i  = 32'h400;
    sb_data_i  = 32'h00000077;
    nxt();
    cache_ready_i = 1'b1;
    nxt();
    cache_ready_i = 1'b0;
    cache_rsp_i   = 1'b1;
    #2;
    rsn_i = 1'b0;
    #1;
    chk("arst_req", cache_req_o, 1'b0);
    chk("arst_we", cache_we_o, 1'b0);
    chk("arst_addr", cache_addr_o, 32'h0);
    chk("arst_data", cache_data_o, 32'h0);
    chk("arst_pop", sb_pop_o, 1'b0);
    chk("arst_done", ld_done_o, 1'b0);
    @(posedge clk_i);
    #3;
    rsn_i     = 1'b1;
    ld_req_i  = 1'b1;
    ld_addr_i = 32'h44;
    @(negedge clk_i);
    chk("arst_no_pop", sb_pop_o, 1'b0);
    chk("arst_idle", cache_req_o, 1'b0);
    nxt();
    cache_rsp_i = 1'b0;
    @(negedge clk_i);
    chk("arst_no_pop2", sb_pop_o, 1'b0);
    chk("arst_grant_req", cache_req_o, 1'b1);
    chk("arst_grant_ld", cache_we_o, 1'b0);
    chk("arst_grant_addr", cache_addr_o, 32'h44);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/segre_sb_drain_arbiter.md
Name: segre_sb_drain_arbiter

Overview:
Owns the single data-cache port shared by pipeline load misses and store-buffer drains. Sequences one cache transaction at a time. Its pop pulse drives the store buffer's flush_chance_i, so a store-buffer entry is released only after the cache confirms the write. Also implements a drain-all fence and a starvation guard, so continuous loads cannot block store drains indefinitely.

Parameters:
ADDR_SIZE, segre_pkg::ADDR_SIZE, address width
WORD_SIZE, segre_pkg::WORD_SIZE, data width
STARVE_LIMIT, segre_pkg::SB_STARVE_LIMIT (4), consecutive load grants allowed while a drain is pending

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset; asynchronous, active-low
ld_req_i  in  1  load miss pending; level, held until ld_done_o
ld_addr_i  in  ADDR_SIZE  load address; stable while ld_req_i
ld_memop_i  in  memop_data_type_e  load size
ld_done_o  out  1  one-cycle pulse: load data valid
ld_data_o  out  WORD_SIZE  load data; valid with ld_done_o
sb_valid_i  in  1  store-buffer tail entry valid
sb_full_i  in  1  store buffer full
sb_addr_i  in  ADDR_SIZE  tail entry address
sb_data_i  in  WORD_SIZE  tail entry data
sb_memop_i  in  memop_data_type_e  tail entry size
sb_pop_o  out  1  one-cycle pulse: tail written to cache, release it
fence_i  in  1  drain-all request; level, held until fence_done_o
fence_done_o  out  1  one-cycle pulse: store buffer empty
stall_o  out  1  pipeline stall
cache_req_o  out  1  cache request valid
cache_we_o  out  1  1 = store, 0 = load
cache_addr_o  out  ADDR_SIZE  request address
cache_data_o  out  WORD_SIZE  store data
cache_memop_o  out  memop_data_type_e  access size
cache_ready_i  in  1  cache accepts request this cycle
cache_rsp_i  in  1  transaction complete; arrives at least 1 cycle after acceptance
cache_rdata_i  in  WORD_SIZE  load data; valid with cache_rsp_i

Behaviour:
- Reset (rsn_i=0, asynchronous):
  - state = IDLE; starvation counter = 0.
  - All outputs 0, except stall_o, which stays combinational as defined below.
  - An in-flight cache transaction is abandoned; the cache is reset on the same rsn_i.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT, FENCE_DONE.
- IDLE grant priority, evaluated once per cycle:
  1. fence_i & sb_valid_i -> ST_REQ
  2. fence_i & !sb_valid_i -> FENCE_DONE
  3. sb_full_i & sb_valid_i -> ST_REQ
  4. sb_valid_i & counter == STARVE_LIMIT -> ST_REQ
  5. ld_req_i -> LD_REQ
  6. sb_valid_i -> ST_REQ
  7. otherwise stay in IDLE
- Payload latch: on a grant, addr/data/memop/we are registered from the winning source. cache_* outputs are driven from these registers and stay stable until accepted.
- LD_REQ / ST_REQ: cache_req_o = 1. On cache_ready_i, move to LD_WAIT / ST_WAIT; next cycle cache_req_o = 0.
- LD_WAIT: on cache_rsp_i, register cache_rdata_i. ld_done_o = 1 for exactly the next cycle; state returns to IDLE in that same cycle.
- ST_WAIT: on cache_rsp_i, sb_pop_o = 1 for exactly the next cycle; state returns to IDLE.
- Pop-to-grant gap: the store buffer updates its tail on the pop edge. The arbiter must not regrant a drain in the same cycle sb_pop_o is high, because sb_valid_i may still show the old entry; that cycle counts as a no-grant cycle.
- FENCE_DONE: fence_done_o = 1 for one cycle, then IDLE. The requester drops fence_i in the following cycle.
- While fence_i = 1, loads are never granted.
- Starvation counter:
  - Width $clog2(STARVE_LIMIT+1).
  - +1 on each load grant made while sb_valid_i = 1; saturates at STARVE_LIMIT.
  - Cleared on any drain grant.
- stall_o = (ld_req_i & !ld_done_o) | (fence_i & !fence_done_o) | sb_full_i. Combinational.
- Latency: grant-to-cache_req_o is 1 cycle. Minimum load is 4 cycles from ld_req_i to ld_done_o (IDLE, LD_REQ, LD_WAIT, done), given ready in the first REQ cycle and rsp 1 cycle later.
- cache_ready_i or cache_rsp_i outside the REQ/WAIT states is ignored.

Decomposition:
- segre_pkg gains:
  - sb_arb_state_e enum (6 states)
  - SB_STARVE_LIMIT constant
- memop_data_type_e is reused from segre_pkg.
- No sub-module. The FSM, payload registers and counter fit in one module of about 200 lines.

Test Plan:
1. Reset mid ST_WAIT (rsn_i low for 1 cycle, asynchronously) -> all outputs 0 immediately, no sb_pop_o after release, first grant follows normal priority.
2. Load: ld_addr_i=0x40, cache_ready_i on the 2nd REQ cycle, cache_rsp_i 3 cycles later with 0xDEADBEEF -> single ld_done_o pulse, ld_data_o=0xDEADBEEF, stall_o high until that pulse.
3. Drain: sb_valid_i with addr 0x100, data 0xA5A5A5A5, memop WORD -> cache_req_o=1, we=1, matching payload held through 3 not-ready cycles; exactly one sb_pop_o after rsp.
4. Starvation with STARVE_LIMIT=4: ld_req_i and sb_valid_i held continuously -> grant order L,L,L,L,S,L,L,L,L,S.
5. sb_full_i=1 with ld_req_i=1 -> drain granted first, load after pop; stall_o high throughout.
6. Fence with 2 valid entries plus a pending load -> S, S, fence_done_o one pulse, then L; no load issued before fence_done_o.
